// File: rtl/mram_ctrl_pkg.sv
// Shared types for the MRAM request controller: FSM states, captured request,
// and the byte-offset width helper used for the alignment check.
package mram_ctrl_pkg;

  localparam int MRAM_ADDR_W = 32;
  localparam int MRAM_DATA_W = 64;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_WAKE    = 3'd1,
    ST_IDLE    = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RSP     = 3'd5
  } mram_ctrl_state_e;

  // Sized for the default bus geometry; the top is instantiated with matching widths.
  typedef struct packed {
    logic                   write;
    logic [MRAM_ADDR_W-1:0] addr;
    logic [MRAM_DATA_W-1:0] wdata;
  } mram_req_t;

  function automatic int byte_off_width(input int data_width);
    return (data_width <= 8) ? 0 : $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/mram_ctrl_if.sv
// SoC-side request/response channel of the MRAM controller.
// Handshake: a beat transfers on a clock edge where valid && ready are both 1;
// valid never waits on ready, and payload is held stable while valid && !ready.
interface mram_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mram_pwr_timer.sv
// Single counter shared by the wake-up countdown and the idle power-down count;
// the two uses never overlap, so one register serves both.
module mram_pwr_timer #(
  parameter int CNT_W     = 7,
  parameter int LOAD_VAL  = 7,
  parameter int LIMIT_VAL = 63
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic clr_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic done_o,
  output logic limit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = CNT_W'(LOAD_VAL);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o  = (cnt_q == '0);
  assign limit_o = (cnt_q == CNT_W'(LIMIT_VAL));

endmodule

// File: rtl/mram_ctrl.sv
// MRAM request controller: serialises single-outstanding requests into MRAM
// strobes, returns responses, and manages wake-up / idle power-down.
// Optional read timeout enabled by defining MRAM_CTRL_RD_TIMEOUT_EN.
module mram_ctrl
  import mram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int WAKE_CYCLES  = 8,
  parameter int IDLE_TIMEOUT = 64,
  parameter int RD_TIMEOUT   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mram_ctrl_if.slave            bus,
  output logic                  mram_cs,
  output logic                  mram_read_en,
  output logic                  mram_write_en,
  output logic [ADDR_WIDTH-1:0] mram_addr,
  output logic [DATA_WIDTH-1:0] mram_wdata,
  input  logic [DATA_WIDTH-1:0] mram_rdata,
  input  logic                  mram_ready,
  output logic                  mram_pwr_on,
  output logic                  busy,
  output mram_ctrl_state_e      dbg_state_o
);

  localparam int  OFF_W      = byte_off_width(DATA_WIDTH);
  localparam int  CNT_MAX    = (WAKE_CYCLES > IDLE_TIMEOUT) ? WAKE_CYCLES : IDLE_TIMEOUT;
  localparam int  CNT_W      = $clog2(CNT_MAX + 1);
  localparam int  IDLE_LIMIT = (IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0;
  localparam bit  IDLE_PD_EN = (IDLE_TIMEOUT != 0);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);

  if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
    $error("mram_ctrl: DATA_WIDTH must be a multiple of 8");
  end
  if (WAKE_CYCLES < 1) begin : g_bad_wake_cycles
    $error("mram_ctrl: WAKE_CYCLES must be at least 1");
  end
  if (RD_TIMEOUT < 1) begin : g_bad_rd_timeout
    $error("mram_ctrl: RD_TIMEOUT must be at least 1");
  end

  mram_ctrl_state_e      state_q, state_d;
  mram_req_t             req_q, req_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  pwr_on_q, pwr_on_d;
  logic                  cs_q, cs_d;
  logic                  rd_en_q, rd_en_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic t_load, t_clr, t_inc, t_dec, t_done, t_limit;
  logic accept, misaligned, rd_expired;

  mram_pwr_timer #(
    .CNT_W    (CNT_W),
    .LOAD_VAL (WAKE_CYCLES - 1),
    .LIMIT_VAL(IDLE_LIMIT)
  ) u_pwr_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (t_load),
    .clr_i  (t_clr),
    .inc_i  (t_inc),
    .dec_i  (t_dec),
    .done_o (t_done),
    .limit_o(t_limit)
  );

`ifdef MRAM_CTRL_RD_TIMEOUT_EN
  localparam int RD_W = $clog2(RD_TIMEOUT + 1);
  logic [RD_W-1:0] rd_cnt_q, rd_cnt_d;

  assign rd_cnt_d   = (state_q == ST_RD_WAIT) ? rd_cnt_q + RD_W'(1) : '0;
  assign rd_expired = (rd_cnt_q == RD_W'(RD_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
    end
  end
`else
  assign rd_expired = 1'b0;
`endif

  assign bus.req_ready = (state_q == ST_IDLE) && !rsp_valid_q;
  assign accept        = bus.req_valid && bus.req_ready;
  assign misaligned    = (bus.req_addr & OFF_MASK) != '0;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    pwr_on_d    = pwr_on_q;
    t_load      = 1'b0;
    t_clr       = 1'b0;
    t_inc       = 1'b0;
    t_dec       = 1'b0;
    unique case (state_q)
      ST_OFF: begin
        // The waking request stays on the bus and is accepted later from IDLE.
        if (bus.req_valid) begin
          state_d  = ST_WAKE;
          pwr_on_d = 1'b1;
          t_load   = 1'b1;
        end
      end
      ST_WAKE: begin
        if (t_done) state_d = ST_IDLE;
        else        t_dec   = 1'b1;
      end
      ST_IDLE: begin
        if (accept) begin
          req_d = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};
          t_clr = 1'b1;
          if (misaligned) begin
            state_d     = ST_RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d = ST_ISSUE;
          end
        end else if (IDLE_PD_EN && t_limit) begin
          state_d  = ST_OFF;
          pwr_on_d = 1'b0;
          t_clr    = 1'b1;
        end else if (IDLE_PD_EN) begin
          t_inc = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (req_q.write) begin
          state_d     = ST_RSP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end else begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (mram_ready) begin
          state_d     = ST_RSP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = mram_rdata;
        end else if (rd_expired) begin
          state_d     = ST_RSP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      ST_RSP: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          t_clr       = 1'b1;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  // Strobes are registered from the next state so they line up with ISSUE.
  always_comb begin
    cs_d    = (state_d == ST_ISSUE);
    rd_en_d = cs_d && !req_d.write;
    wr_en_d = cs_d && req_d.write;
    addr_d  = cs_d ? req_d.addr  : addr_q;
    wdata_d = cs_d ? req_d.wdata : wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OFF;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      pwr_on_q    <= 1'b0;
      cs_q        <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      pwr_on_q    <= pwr_on_d;
      cs_q        <= cs_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign mram_cs       = cs_q;
  assign mram_read_en  = rd_en_q;
  assign mram_write_en = wr_en_q;
  assign mram_addr     = addr_q;
  assign mram_wdata    = wdata_q;
  assign mram_pwr_on   = pwr_on_q;
  assign busy          = (state_q != ST_OFF) && (state_q != ST_IDLE);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mram_ctrl.sv
// Bench for mram_ctrl: table of request/response vectors against a small MRAM
// model (read latency 2), plus wake, idle power-down and reset-mid-read sequences.
module tb_mram_ctrl;
  import mram_ctrl_pkg::*;

  localparam int RD_TIMEOUT = 32;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [63:0] wdata;
    int          hold;
    int          exp_wait;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_cs;
  } vec_t;

  logic clk, rst_n;
  logic mram_cs, mram_read_en, mram_write_en, mram_ready, mram_pwr_on, busy;
  logic [31:0] mram_addr;
  logic [63:0] mram_wdata, mram_rdata;
  mram_ctrl_state_e dbg_state;

  mram_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bus ();

  mram_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .WAKE_CYCLES(8),
    .IDLE_TIMEOUT(64), .RD_TIMEOUT(RD_TIMEOUT)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .mram_cs      (mram_cs),
    .mram_read_en (mram_read_en),
    .mram_write_en(mram_write_en),
    .mram_addr    (mram_addr),
    .mram_wdata   (mram_wdata),
    .mram_rdata   (mram_rdata),
    .mram_ready   (mram_ready),
    .mram_pwr_on  (mram_pwr_on),
    .busy         (busy),
    .dbg_state_o  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MRAM model: read data valid READ_LAT=2 edges after the strobe is sampled
  logic [63:0] mem [0:255] = '{8: 64'h0123_4567_89AB_CDEF, default: 64'h0};
  logic [1:0]  rd_pipe;
  logic        mdl_ready, withhold, stray_ready;
  logic [63:0] mdl_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe   <= 2'b00;
      mdl_ready <= 1'b0;
      mdl_rdata <= 64'h0;
    end else begin
      rd_pipe   <= {rd_pipe[0], mram_cs & mram_read_en};
      mdl_ready <= rd_pipe[1] & ~withhold;
      if (rd_pipe[1]) mdl_rdata <= mem[mram_addr[10:3]];
      if (mram_cs && mram_write_en) mem[mram_addr[10:3]] <= mram_wdata;
    end
  end

  assign mram_ready = mdl_ready | stray_ready;
  assign mram_rdata = mdl_rdata;

  int cs_cnt = 0, rd_cnt = 0, wr_cnt = 0;
  always @(negedge clk) begin
    if (mram_cs)       cs_cnt++;
    if (mram_read_en)  rd_cnt++;
    if (mram_write_en) wr_cnt++;
  end

  // scoreboard
  logic [63:0] exp_q[$];
  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: one full request/response transaction
  task automatic run_req(input vec_t v);
    int n, lat, cs0, rd0, wr0, cs1;
    logic [63:0] snap, exp_d;
    logic stable, rr_seen;
    bus.req_valid = 1'b1;
    bus.req_write = v.write;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    n = 0;
    while (!bus.req_ready && n < 200) begin step(); n++; end
    check("req_wait", n, v.exp_wait);
    cs0 = cs_cnt; rd0 = rd_cnt; wr0 = wr_cnt;
    step();
    exp_q.push_back(v.exp_rdata);
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 200) begin step(); lat++; end
    check("rsp_latency", lat, v.exp_lat);
    exp_d = exp_q.pop_front();
    check("rsp_rdata", bus.rsp_rdata, exp_d);
    check("rsp_err", bus.rsp_err, v.exp_err);
    check("cs_pulses", cs_cnt - cs0, v.exp_cs);
    check("rd_pulses", rd_cnt - rd0, v.write ? 0 : v.exp_cs);
    check("wr_pulses", wr_cnt - wr0, v.write ? v.exp_cs : 0);
    snap = bus.rsp_rdata; stable = 1'b1; rr_seen = 1'b0; cs1 = cs_cnt;
    for (int i = 0; i < v.hold; i++) begin
      step();
      if (!bus.rsp_valid || bus.rsp_rdata !== snap) stable = 1'b0;
      if (bus.req_ready) rr_seen = 1'b1;
    end
    if (v.hold > 0) begin
      check("bp_rsp_stable", stable, 1'b1);
      check("bp_req_ready", rr_seen, 1'b0);
      check("bp_no_strobe", cs_cnt - cs1, 0);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check("rsp_drop", bus.rsp_valid, 1'b0);
  endtask

  task automatic start_read(input logic [31:0] addr);
    check("rd_start_ready", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = addr;
    step();
    bus.req_valid = 1'b0;
    step();
    check("rd_wait_state", dbg_state, ST_RD_WAIT);
  endtask

  vec_t vecs[10];
  vec_t cold;

  initial begin
    int n;
    logic seen;
    vecs[0] = '{write:1'b1, addr:32'h100, wdata:64'hDEADBEEF_CAFEF00D, hold:0, exp_wait:0, exp_rdata:64'h0,                  exp_err:1'b0, exp_lat:1, exp_cs:1};
    vecs[1] = '{write:1'b0, addr:32'h100, wdata:64'h0,                 hold:0, exp_wait:0, exp_rdata:64'hDEADBEEF_CAFEF00D, exp_err:1'b0, exp_lat:4, exp_cs:1};
    vecs[2] = '{write:1'b0, addr:32'h103, wdata:64'h0,                 hold:0, exp_wait:0, exp_rdata:64'h0,                  exp_err:1'b1, exp_lat:0, exp_cs:0};
    vecs[3] = '{write:1'b1, addr:32'h108, wdata:64'h1111_2222_3333_4444, hold:0, exp_wait:0, exp_rdata:64'h0,                exp_err:1'b0, exp_lat:1, exp_cs:1};
    vecs[4] = '{write:1'b0, addr:32'h040, wdata:64'h0,                 hold:10, exp_wait:0, exp_rdata:64'h0123_4567_89AB_CDEF, exp_err:1'b0, exp_lat:4, exp_cs:1};
    vecs[5] = '{write:1'b0, addr:32'h108, wdata:64'h0,                 hold:0, exp_wait:0, exp_rdata:64'h1111_2222_3333_4444, exp_err:1'b0, exp_lat:4, exp_cs:1};
    vecs[6] = '{write:1'b1, addr:32'h0FF, wdata:64'hA5A5_A5A5_A5A5_A5A5, hold:0, exp_wait:0, exp_rdata:64'h0,                exp_err:1'b1, exp_lat:0, exp_cs:0};
    vecs[7] = '{write:1'b0, addr:32'h0F8, wdata:64'h0,                 hold:0, exp_wait:0, exp_rdata:64'h0,                  exp_err:1'b0, exp_lat:4, exp_cs:1};
    vecs[8] = '{write:1'b1, addr:32'h7F8, wdata:64'hFFFF_0000_FFFF_0000, hold:0, exp_wait:0, exp_rdata:64'h0,                exp_err:1'b0, exp_lat:1, exp_cs:1};
    vecs[9] = '{write:1'b0, addr:32'h7F8, wdata:64'h0,                 hold:0, exp_wait:0, exp_rdata:64'hFFFF_0000_FFFF_0000, exp_err:1'b0, exp_lat:4, exp_cs:1};

    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b0; withhold = 1'b0; stray_ready = 1'b0;
    repeat (3) step();
    check("rst_outputs", {mram_pwr_on, mram_cs, bus.rsp_valid, bus.req_ready, busy}, 5'b0);
    rst_n = 1'b1;
    repeat (3) step();
    check("off_state", dbg_state, ST_OFF);
    check("off_pwr", mram_pwr_on, 1'b0);
    check("off_req_ready", bus.req_ready, 1'b0);

    // cold read: first edge with req_valid powers up, req_ready 8 edges later
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h40;
    step();
    check("wake_pwr_on", mram_pwr_on, 1'b1);
    check("wake_req_ready", bus.req_ready, 1'b0);
    check("wake_busy", busy, 1'b1);
    cold = '{write:1'b0, addr:32'h40, wdata:64'h0, hold:0, exp_wait:8, exp_rdata:64'h0123_4567_89AB_CDEF, exp_err:1'b0, exp_lat:4, exp_cs:1};
    run_req(cold);

    // stray mram_ready outside RD_WAIT
    stray_ready = 1'b1;
    step();
    stray_ready = 1'b0;
    step();
    check("stray_rsp_valid", bus.rsp_valid, 1'b0);
    check("stray_state", dbg_state, ST_IDLE);

    for (int i = 0; i < 10; i++) run_req(vecs[i]);

    // idle power-down 64 edges after entering IDLE
    n = 0;
    while (mram_pwr_on && n < 200) begin step(); n++; end
    check("idle_pd_cycles", n, 64);
    check("idle_pd_state", dbg_state, ST_OFF);

    cold = '{write:1'b0, addr:32'h100, wdata:64'h0, hold:0, exp_wait:9, exp_rdata:64'hDEADBEEF_CAFEF00D, exp_err:1'b0, exp_lat:4, exp_cs:1};
    run_req(cold);

    // a request in the 64th idle cycle wins over power-down
    repeat (63) step();
    check("pd_edge_pwr", mram_pwr_on, 1'b1);
    cold = '{write:1'b0, addr:32'h108, wdata:64'h0, hold:0, exp_wait:0, exp_rdata:64'h1111_2222_3333_4444, exp_err:1'b0, exp_lat:4, exp_cs:1};
    run_req(cold);
    check("pd_edge_pwr_after", mram_pwr_on, 1'b1);

    withhold = 1'b1;
    start_read(32'h40);
`ifdef MRAM_CTRL_RD_TIMEOUT_EN
    n = 1;
    while (!bus.rsp_valid && n < 200) begin step(); n++; end
    check("rd_timeout_lat", n, RD_TIMEOUT + 1);
    check("rd_timeout_err", bus.rsp_err, 1'b1);
    check("rd_timeout_rdata", bus.rsp_rdata, 64'h0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    start_read(32'h40);
    repeat (3) step();
`else
    repeat (40) step();
    check("rd_wait_no_rsp", bus.rsp_valid, 1'b0);
    check("rd_wait_hold", dbg_state, ST_RD_WAIT);
`endif
    check("mid_read_busy", busy, 1'b1);

    // asynchronous reset mid-read
    rst_n = 1'b0;
    #1;
    check("rst_flags", {mram_pwr_on, mram_cs, mram_read_en, mram_write_en,
                        bus.rsp_valid, bus.rsp_err, bus.req_ready, busy}, 8'h0);
    check("rst_addr", mram_addr, 32'h0);
    check("rst_wdata", mram_wdata, 64'h0);
    check("rst_rdata", bus.rsp_rdata, 64'h0);
    check("rst_state", dbg_state, ST_OFF);
    withhold = 1'b0;
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.rsp_valid || mram_pwr_on) seen = 1'b1;
    end
    check("post_rst_quiet", seen, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
